// File: rtl/eight_bit_serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b - bin, one bit per clock, LSB first; optional signed overflow via SERIAL_SUB_OVF_EN.
// Latency: WIDTH cycles from the accepting edge to the done pulse; one operation per WIDTH+2 edges at best.
// Backpressure: start is sampled only in IDLE and ignored while busy; there is no output stall.
module eight_bit_serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             last_bit;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [CW-1:0]    cnt;
    logic             brw;

    logic             x;
    logic             y;
    logic             d;
    logic             brw_nxt;
    logic [WIDTH-1:0] res_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last_bit  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (cnt == LAST) begin
                    last_bit  = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    // Full-subtractor step on the current LSBs; the new bit enters at the MSB end
    always_comb begin
        x       = a_sr[0];
        y       = b_sr[0];
        d       = x ^ y ^ brw;
        brw_nxt = (~x & y) | (~(x ^ y) & brw);
        res_nxt = {d, res_sr[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            cnt    <= '0;
            brw    <= 1'b0;
        end else if (accept) begin
            a_sr   <= a;
            b_sr   <= b;
            res_sr <= '0;
            cnt    <= '0;
            brw    <= bin;
        end else if (state == S_SHIFT) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            res_sr <= res_nxt;
            cnt    <= cnt + 1'b1;
            brw    <= brw_nxt;
        end
    end

    // Visible result only updates on the edge entering DONE, never mid-shift
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff <= '0;
            bout <= 1'b0;
        end else if (last_bit) begin
            diff <= res_nxt;
            bout <= brw_nxt;
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    // On the final step x/y are the operand MSBs and d is the result MSB
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (last_bit) begin
            ovf <= (x ^ y) & (d ^ x);
        end
    end
`endif

endmodule

// File: doc/eight_bit_serial_subtractor.md
# eight_bit_serial_subtractor

Bit-serial counterpart to the team's parallel 8-bit adder: computes A − B − Bin one bit per clock, LSB first, and returns the difference and borrow-out. It uses a start/busy/done handshake. It sits beside the adder as the inverse operation, trading area for a WIDTH-cycle latency, and is driven by a controller or testbench that presents operands and waits for `done`.

## Interface
- `WIDTH`, default 8: operand and result width in bits (≥2).
- `clk`  input  1  single clock; all state changes on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  request to begin; sampled only in IDLE.
- `a`  input  WIDTH  minuend, unsigned; captured on the accepting edge.
- `b`  input  WIDTH  subtrahend, unsigned; captured on the accepting edge.
- `bin`  input  1  borrow-in; captured on the accepting edge.
- `busy`  output  1  high in SHIFT and DONE.
- `done`  output  1  one-cycle pulse when the result is valid.
- `diff`  output  WIDTH  registered result; holds until the next completed operation.
- `bout`  output  1  registered borrow-out; holds with `diff`.
- `ovf`  output  1  signed overflow; present only with `SERIAL_SUB_OVF_EN`.

## Operation
- Arithmetic:
  - `diff` = (a − b − bin) mod 2^WIDTH.
  - `bout` = 1 iff a < b + bin, treating a and b as unsigned.
- Per-bit step, using operand LSBs x, y and running borrow r:
  - d = x ^ y ^ r.
  - r' = (~x & y) | (~(x ^ y) & r).
  - d shifts into the MSB of an internal result shift register.
  - Operand registers shift right by one.
- State machine:
  - IDLE: if `start`=1, capture a/b/bin, clear bit counter, go to SHIFT. Otherwise stay.
  - SHIFT: process one bit per cycle. After the WIDTH-th bit, load `diff`/`bout` (and `ovf`) from internal state and go to DONE.
  - DONE: `done`=1 for this cycle only. Unconditionally return to IDLE.
- `start` is ignored in SHIFT and DONE. A request held high through DONE is accepted on the first IDLE edge.
- Operand inputs may change freely after the accepting edge; the result depends only on the captured values.
- `diff`/`bout` never show partial results: they change only on the edge entering DONE.

## Timing
- Reset (asynchronous, `rst_n`=0):
  - State goes to IDLE.
  - `busy`, `done`, `diff`, `bout` (and `ovf`) go to 0 immediately.
  - The shift registers and counter are cleared.
- Reset mid-operation aborts the operation: no `done` pulse, and the outputs stay 0 until a later operation completes.
- `start` accepted at edge k:
  - `busy`=1 after edge k.
  - Bits are processed on edges k+1 … k+WIDTH.
  - Result outputs are valid and `done`=1 after edge k+WIDTH.
  - `done`=0 and `busy`=0 after edge k+WIDTH+1.
- Start-to-done latency is WIDTH cycles. Minimum spacing between accepted starts is WIDTH+2 edges.
- Back-to-back: `start` held constantly high yields one operation every WIDTH+2 cycles.

## Configuration
- Macro: `SERIAL_SUB_OVF_EN`.
- Defined:
  - Port `ovf` exists.
  - `ovf` = (a[MSB] ≠ b[MSB]) && (diff[MSB] ≠ a[MSB]), computed from the captured operands and the final difference. `bin` is included in the difference.
  - `ovf` is registered with `diff`, resets to 0, and holds like `diff`.
- Undefined: no `ovf` port and no associated logic; all other behaviour is identical.

## Test plan
- Basic result and latency: a=200, b=100, bin=0 -> `diff`=100, `bout`=0. `done` pulses exactly 8 cycles after the accepting edge, lasting 1 cycle. `busy` is high for 9 cycles.
- Borrow propagation:
  - a=100, b=100, bin=1 -> `diff`=255, `bout`=1.
  - a=0, b=0, bin=1 -> `diff`=255, `bout`=1.
  - a=255, b=255, bin=0 -> `diff`=0, `bout`=0.
  - a=34, b=214, bin=1 -> `diff`=75, `bout`=1.
- Ignored start: start a=50, b=20, bin=0, then pulse `start` with a=7, b=9 at cycles 3 and 8 -> exactly one `done`, `diff`=30, `bout`=0. Held `start` is accepted only after returning to IDLE.
- Reset abort: assert `rst_n`=0 at cycle 4 of an operation -> `busy`/`done`/`diff`/`bout` are 0 immediately, and no `done` follows release. A new operation a=134, b=2, bin=0 then gives `diff`=132, `bout`=0.
- Output stability: during SHIFT, `diff`/`bout` hold the previous result (e.g. 132) until the edge entering DONE.
- Overflow (macro defined):
  - 0x80 − 0x01 − 0 -> `diff`=0x7F, `ovf`=1.
  - 0x7F − 0xFF − 0 -> `diff`=0x80, `ovf`=1.
  - 0x10 − 0x05 − 0 -> `ovf`=0.
  - With the macro undefined, the build has no `ovf` port.
